shot_clock_ctrl: RTL
====================

// Module: shot_clock_ctrl
//
// PURPOSE
// - Parametrised shot-clock controller; next generation of the basic shot counter.
// - Counts down from a selectable reload value, one count per prescaled tick.
// - Supports run/pause control, full or short reload, a one-cycle expiry pulse and a timed buzzer.
// - Sits between the game-control inputs and the display/horn drivers of the scoreboard design.
//
// PARAMETERS
// CNT_W       5    width of count output
// FULL_VAL    24   full reload value; legal range 1 .. 2**CNT_W-1
// SHORT_VAL   14   short reload value; legal range 1 .. FULL_VAL
// TICK_DIV    100  clk cycles per count tick; >=1 (1 = tick every cycle)
// BUZZ_TICKS  3    buzzer duration in ticks; >=1
// WARN_VAL    5    warning threshold (used only with SHOT_WARN_EN)
//
// PORTS
// clk           in   1      system clock, rising edge
// rst           in   1      synchronous reset, active-high
// start         in   1      level/pulse: begin or resume counting
// pause         in   1      hold count, stop prescaler
// reload_full   in   1      load FULL_VAL
// reload_short  in   1      load SHORT_VAL
// count         out  CNT_W  current shot-clock value
// running       out  1      1 while in RUN
// shoot         out  1      one-cycle pulse in the cycle count becomes 0
// buzz          out  1      horn enable, BUZZ_TICKS*TICK_DIV cycles long
// warn          out  1      present only with SHOT_WARN_EN
//
// BEHAVIOUR
// - Reset values: state IDLE, count=FULL_VAL, prescaler=0, buzz timer=0.
//   Outputs running=0, shoot=0, buzz=0, warn=0.
// - All outputs are registered.
// - Input priority: rst > reload_full > reload_short > pause > start.
// - FSM states: IDLE, RUN, PAUSE, EXPIRED.
//   - IDLE   : start -> RUN; prescaler cleared on entry to RUN.
//   - RUN    : pause -> PAUSE.
//              On tick with count>1: count-1.
//              On tick with count==1: count=0, state EXPIRED, shoot=1 for 1 cycle, buzz=1.
//   - PAUSE  : count and prescaler frozen (partial tick retained); start -> RUN.
//   - EXPIRED: count held at 0; start and pause ignored; only a reload exits (-> IDLE).
// - Reload handling:
//   - A reload loads the selected value and clears the prescaler.
//   - State is kept in IDLE/RUN/PAUSE; EXPIRED -> IDLE.
//   - A reload in the same cycle as the final tick wins: no shoot, no buzz start.
//   - reload_full and reload_short together: FULL_VAL is loaded.
// - Tick generation:
//   - Prescaler counts 0..TICK_DIV-1 only in RUN; tick fires on the cycle it equals TICK_DIV-1, then it wraps to 0.
// - Latency:
//   - start at cycle n -> running=1 at n+1.
//   - First decrement TICK_DIV cycles after entering RUN from IDLE.
// - Buzzer:
//   - Once started, runs its full duration regardless of reloads.
//   - Only rst truncates it.
// - Reset mid-operation: every state returns to reset values on the next edge.
//
// CONFIGURATION
// - SHOT_WARN_EN defined:
//   - warn=1 while state is RUN or PAUSE and 0 < count <= WARN_VAL.
//   - Registered; updates on the same edge as count.
// - SHOT_WARN_EN undefined: warn port and all warn logic are absent.
//
// STRUCTURE
// - Package shot_pkg holds the state encoding localparams (IDLE, RUN, PAUSE, EXPIRED).
//   It also holds the parameter-legality check constants.
// - Sub-module shot_tick_gen: prescaler with enable and clear inputs and a tick output, parametrised by TICK_DIV.
//
// TESTING (TICK_DIV=4, FULL_VAL=24, SHORT_VAL=14, BUZZ_TICKS=3)
// - rst high 2 cycles -> count=24; running, shoot, buzz all 0.
// - start 1 cycle -> running=1 next cycle; count=23 after 4 cycles.
//   count=0 after 96 cycles: shoot high exactly 1 cycle, buzz high exactly 12 cycles.
// - pause at count=10 for 20 cycles -> count holds 10; start -> decrement resumes with the retained prescaler phase.
// - reload_short in RUN at count=3 -> count=14, running stays 1.
//   reload_full and reload_short together -> count=24.
// - reload_full on the cycle of the 1->0 tick -> count=24, shoot=0, buzz=0.
//   From EXPIRED, reload_short -> IDLE, count=14.
// - rst during RUN at count=7 with buzz active -> next cycle count=24, running=0, buzz=0.
//   With SHOT_WARN_EN: warn rises when count=5 and falls at 0.

Source files
------------

// File: rtl/shot_pkg.sv
// Shared definitions for the shot-clock controller: FSM state encoding and
// the parameter-legality floors applied by the top level.
package shot_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    localparam int unsigned MIN_TICK_DIV   = 1;
    localparam int unsigned MIN_BUZZ_TICKS = 1;
    localparam int unsigned MIN_RELOAD_VAL = 1;

    function automatic int unsigned at_least(input int unsigned v, input int unsigned lo);
        return (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/shot_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and raises tick_o on the
// terminal count. clr_i takes priority over en_i.
module shot_tick_gen #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = tick_o ? '0 : cnt_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot-clock controller: reloadable countdown with run/pause, expiry pulse
// and timed buzzer. Optional warn output enabled by defining SHOT_WARN_EN.
module shot_clock_ctrl
    import shot_pkg::*;
#(
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned FULL_VAL   = 24,
    parameter int unsigned SHORT_VAL  = 14,
    parameter int unsigned TICK_DIV   = 100,
    parameter int unsigned BUZZ_TICKS = 3,
    parameter int unsigned WARN_VAL   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             reload_full,
    input  logic             reload_short,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             shoot,
`ifdef SHOT_WARN_EN
    output logic             warn,
`endif
    output logic             buzz
);

    localparam int unsigned TDIV     = at_least(TICK_DIV, MIN_TICK_DIV);
    localparam int unsigned BUZZ_CYC = at_least(BUZZ_TICKS, MIN_BUZZ_TICKS) * TDIV;
    localparam int unsigned BT_W     = $clog2(BUZZ_CYC + 1);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(at_least(FULL_VAL, MIN_RELOAD_VAL));
    localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(at_least(SHORT_VAL, MIN_RELOAD_VAL));

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [BT_W-1:0]  btmr_q, btmr_d;
    logic             running_q, shoot_q, buzz_q;
    logic             reload, expire, tick, tick_en, tick_clr;

    assign reload = reload_full || reload_short;

    // Enable/clear are decoded apart from the FSM so tick never feeds back into them.
    assign tick_en  = (state_q == RUN) && !pause && !reload;
    assign tick_clr = reload || ((state_q == IDLE) && start && !pause);

    shot_tick_gen #(
        .TICK_DIV(TDIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (tick_en),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        expire  = 1'b0;
        if (reload) begin
            count_d = reload_full ? FULL_C : SHORT_C;
            if (state_q == EXPIRED)
                state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (!pause && start) state_d = RUN;
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        if (count_q > CNT_W'(1)) begin
                            count_d = count_q - CNT_W'(1);
                        end else begin
                            count_d = '0;
                            state_d = EXPIRED;
                            expire  = 1'b1;
                        end
                    end
                end
                PAUSE: if (!pause && start) state_d = RUN;
                EXPIRED: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // Buzzer runs its full length once started; only rst cuts it short.
    always_comb begin
        btmr_d = btmr_q;
        if (expire)
            btmr_d = BT_W'(BUZZ_CYC);
        else if (btmr_q != '0)
            btmr_d = btmr_q - BT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= FULL_C;
            btmr_q    <= '0;
            running_q <= 1'b0;
            shoot_q   <= 1'b0;
            buzz_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            btmr_q    <= btmr_d;
            running_q <= (state_d == RUN);
            shoot_q   <= expire;
            buzz_q    <= (btmr_d != '0);
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign shoot   = shoot_q;
    assign buzz    = buzz_q;

`ifdef SHOT_WARN_EN
    logic warn_q;

    always_ff @(posedge clk) begin
        if (rst)
            warn_q <= 1'b0;
        else
            warn_q <= ((state_d == RUN) || (state_d == PAUSE)) &&
                      (count_d != '0) && (count_d <= CNT_W'(WARN_VAL));
    end

    assign warn = warn_q;
`endif

endmodule
